// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: ALU commands, ARM opcode/cond constants, flag indices and opcode encoder
package alu_issue_pkg;
  localparam logic [3:0] CMD_NOP = 4'b0000, CMD_MOV = 4'b0001, CMD_ADD = 4'b0010, CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100, CMD_SBC = 4'b0101, CMD_AND = 4'b0110, CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000, CMD_MVN = 4'b1001;
  localparam logic [3:0] OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010, OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_TST = 4'b1000, OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_MVN = 4'b1111;
  localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3, CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7, CC_HI = 4'h8, CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'ha, CC_LT = 4'hb, CC_GT = 4'hc, CC_LE = 4'hd, CC_AL = 4'he;
  localparam int FN = 3, FZ = 2, FC = 1, FV = 0;
  typedef struct packed {
    logic [3:0] cmd;
    logic       s;
    logic       wb;
  } enc_t;
  // Memory address calculation overrides the opcode; compares set flags but never write back
  function automatic enc_t encode(logic [3:0] op, logic s, logic mem);
    enc_t e;
    e = '{cmd: CMD_NOP, s: 1'b0, wb: 1'b0};
    if (mem) e = '{cmd: CMD_ADD, s: 1'b0, wb: 1'b1};
    else
      case (op)
        OP_MOV: e = '{cmd: CMD_MOV, s: s, wb: 1'b1};
        OP_MVN: e = '{cmd: CMD_MVN, s: s, wb: 1'b1};
        OP_ADD: e = '{cmd: CMD_ADD, s: s, wb: 1'b1};
        OP_ADC: e = '{cmd: CMD_ADC, s: s, wb: 1'b1};
        OP_SUB: e = '{cmd: CMD_SUB, s: s, wb: 1'b1};
        OP_SBC: e = '{cmd: CMD_SBC, s: s, wb: 1'b1};
        OP_AND: e = '{cmd: CMD_AND, s: s, wb: 1'b1};
        OP_ORR: e = '{cmd: CMD_ORR, s: s, wb: 1'b1};
        OP_EOR: e = '{cmd: CMD_EOR, s: s, wb: 1'b1};
        OP_CMP: e = '{cmd: CMD_SUB, s: 1'b1, wb: 1'b0};
        OP_TST: e = '{cmd: CMD_AND, s: 1'b1, wb: 1'b0};
        default: e = '{cmd: CMD_NOP, s: 1'b0, wb: 1'b0};
      endcase
    return e;
  endfunction
endpackage

// File: rtl/alu_issue_ctrl_cond_check.sv
// cond_check: evaluates an ARM condition field against {N,Z,C,V}
module cond_check
  import alu_issue_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;
  // Standard ARM condition table; 1111 never passes
  always_comb
    case (cond)
      CC_EQ: pass = z;
      CC_NE: pass = ~z;
      CC_CS: pass = c;
      CC_CC: pass = ~c;
      CC_MI: pass = n;
      CC_PL: pass = ~n;
      CC_VS: pass = v;
      CC_VC: pass = ~v;
      CC_HI: pass = c & ~z;
      CC_LS: pass = ~c | z;
      CC_GE: pass = n == v;
      CC_LT: pass = n != v;
      CC_GT: pass = ~z & (n == v);
      CC_LE: pass = z | (n != v);
      CC_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: ALU issue stage with one EX slot and NZCV status register (option FLAG_FWD_EN)
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter logic [3:0] SR_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_opcode,
  input  logic [3:0] in_cond,
  input  logic       in_s,
  input  logic       in_mem,
  input  logic       stall,
  input  logic       flush,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  output logic       ex_valid,
  output logic       ex_exec,
  output logic [3:0] ex_cmd,
  output logic       ex_carry_in,
  output logic       ex_s,
  output logic       ex_wb,
  output logic [3:0] sr
);
  logic       flag_set, hazard, pass, acc;
  logic [3:0] alu_f, eff;
  enc_t       enc;
  assign alu_f    = {alu_n, alu_z, alu_c, alu_v};
  assign flag_set = ex_valid & ex_exec & ex_s;
`ifdef FLAG_FWD_EN
  assign eff    = flag_set ? alu_f : sr;
  assign hazard = 1'b0;
`else
  assign eff    = sr;
  assign hazard = flag_set;
`endif
  assign in_ready = ~stall & (flush | ~hazard);
  assign acc      = in_valid & in_ready & ~flush;
  assign enc      = encode(in_opcode, in_s, in_mem);
  cond_check u_cond (.cond(in_cond), .flags(eff), .pass(pass));
  // EX slot and status register; stall freezes both, a failed condition squashes flag and result writes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_exec     <= 1'b0;
      ex_cmd      <= CMD_NOP;
      ex_carry_in <= 1'b0;
      ex_s        <= 1'b0;
      ex_wb       <= 1'b0;
      sr          <= SR_RESET;
    end else if (!stall) begin
      if (flag_set) sr <= alu_f;
      ex_valid    <= acc;
      ex_exec     <= acc & pass;
      ex_cmd      <= acc ? enc.cmd : CMD_NOP;
      ex_carry_in <= acc & eff[FC];
      ex_s        <= acc & pass & enc.s;
      ex_wb       <= acc & pass & enc.wb;
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized checks of alu_issue_ctrl against a behavioural model
module tb_alu_issue_ctrl;
`ifdef FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 0, in_s = 0, in_mem = 0, stall = 0, flush = 0;
  logic [3:0] in_opcode = 0, in_cond = 0, alu = 0;
  logic in_ready, ex_valid, ex_exec, ex_carry_in, ex_s, ex_wb;
  logic [3:0] ex_cmd, sr;
  int checks = 0, passed = 0;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_cond(in_cond), .in_s(in_s), .in_mem(in_mem), .stall(stall), .flush(flush),
    .alu_n(alu[3]), .alu_z(alu[2]), .alu_c(alu[1]), .alu_v(alu[0]),
    .ex_valid(ex_valid), .ex_exec(ex_exec), .ex_cmd(ex_cmd), .ex_carry_in(ex_carry_in),
    .ex_s(ex_s), .ex_wb(ex_wb), .sr(sr)
  );

  always #5 clk = ~clk;

  // Opcode table indexed by ARM opcode: command, and kind 0=unsupported 1=normal 2=compare
  logic [3:0] t_cmd [16] = '{6, 8, 4, 0, 2, 3, 5, 0, 6, 0, 4, 0, 7, 1, 0, 9};
  logic [1:0] t_kind [16] = '{1, 1, 1, 0, 1, 1, 1, 0, 2, 0, 2, 0, 1, 1, 0, 1};

  logic m_v, m_x, m_ci, m_s, m_wb;
  logic [3:0] m_cmd, m_sr;
  logic setf, take, ok, es, ewb;
  logic [3:0] f;

  function automatic logic cond_ok(logic [3:0] c, logic [3:0] fl);
    logic n, z, cy, v, r;
    {n, z, cy, v} = fl;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c == 4'hf) return 1'b0;
    if (c == 4'he) return 1'b1;
    return c[0] ? !r : r;
  endfunction

  function automatic logic m_ready();
    return !stall && (flush || FWD || !(m_v && m_x && m_s));
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_v = 0; m_x = 0; m_ci = 0; m_s = 0; m_wb = 0; m_cmd = 0; m_sr = 4'b0000;
    end else if (!stall) begin
      setf = m_v && m_x && m_s;
      f = (FWD && setf) ? alu : m_sr;
      take = in_valid && m_ready() && !flush;
      ok = cond_ok(in_cond, f);
      if (setf) m_sr = alu;
      m_v = take;
      if (take) begin
        if (in_mem) begin
          m_cmd = 4'd2; es = 0; ewb = 1;
        end else begin
          m_cmd = t_cmd[in_opcode];
          es = (t_kind[in_opcode] == 1) ? in_s : (t_kind[in_opcode] == 2);
          ewb = (t_kind[in_opcode] == 1);
        end
        m_x = ok; m_ci = f[1]; m_s = ok && es; m_wb = ok && ewb;
      end
    end

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  always @(negedge clk)
    if (rst_n) begin
      chk("ex_valid", {3'b0, ex_valid}, {3'b0, m_v});
      chk("sr", sr, m_sr);
      chk("in_ready", {3'b0, in_ready}, {3'b0, m_ready()});
      if (m_v) begin
        chk("ex_exec", {3'b0, ex_exec}, {3'b0, m_x});
        chk("ex_cmd", ex_cmd, m_cmd);
        chk("ex_carry_in", {3'b0, ex_carry_in}, {3'b0, m_ci});
        chk("ex_s", {3'b0, ex_s}, {3'b0, m_s});
        chk("ex_wb", {3'b0, ex_wb}, {3'b0, m_wb});
      end
    end

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] c, input logic s,
                       input logic mem, input logic st, input logic fl, input logic [3:0] a);
    in_valid = v; in_opcode = op; in_cond = c; in_s = s; in_mem = mem; stall = st; flush = fl; alu = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    #1;
    chk("rst_sr", sr, 4'b0000);
    chk("rst_ex_valid", {3'b0, ex_valid}, 4'd0);
    chk("rst_in_ready", {3'b0, in_ready}, 4'd1);
    drive(1, 4'b0100, 4'he, 0, 0, 0, 0, 4'h0); tick;
    chk("add_valid", {3'b0, ex_valid}, 4'd1);
    chk("add_cmd", ex_cmd, 4'b0010);
    chk("add_wb", {3'b0, ex_wb}, 4'd1);
    drive(1, 4'b0010, 4'he, 1, 0, 0, 0, 4'h0); tick;
    drive(0, 4'b0000, 4'he, 0, 0, 0, 0, 4'b0110); tick;
    chk("subs_sr", sr, 4'b0110);
    drive(1, 4'b1101, 4'h0, 0, 0, 0, 0, 4'h0); tick;
    chk("moveq_exec", {3'b0, ex_exec}, 4'd1);
    chk("moveq_cmd", ex_cmd, 4'b0001);
    drive(1, 4'b1010, 4'he, 0, 0, 0, 0, 4'h0); tick;
    drive(1, 4'b0100, 4'h1, 0, 0, 0, 0, 4'b0100); #1;
    chk("cmp_addne_ready", {3'b0, in_ready}, {3'b0, FWD});
    tick;
    chk("cmp_addne_bubble", {3'b0, ex_valid}, {3'b0, FWD});
    repeat (FWD ? 0 : 1) tick;
    chk("addne_valid", {3'b0, ex_valid}, 4'd1);
    chk("addne_exec", {3'b0, ex_exec}, 4'd0);
    chk("addne_cmd", ex_cmd, 4'b0010);
    drive(1, 4'b0100, 4'he, 1, 0, 0, 0, 4'h0); tick;
    drive(0, 4'b0000, 4'he, 0, 0, 0, 0, 4'b0010); tick;
    chk("c_set_sr", sr, 4'b0010);
    drive(1, 4'b0101, 4'he, 0, 0, 0, 0, 4'h0); tick;
    chk("adc_carry", {3'b0, ex_carry_in}, 4'd1);
    chk("adc_cmd", ex_cmd, 4'b0011);
    drive(1, 4'b0100, 4'hf, 1, 0, 0, 0, 4'hf); tick;
    chk("nv_exec", {3'b0, ex_exec}, 4'd0);
    drive(0, 4'b0000, 4'he, 0, 0, 0, 0, 4'hf); tick;
    chk("nv_sr", sr, 4'b0010);
    drive(1, 4'b0010, 4'he, 1, 0, 0, 0, 4'h0); tick;
    drive(1, 4'b0100, 4'he, 0, 0, 1, 0, 4'b1001); #1;
    chk("stall_ready", {3'b0, in_ready}, 4'd0);
    repeat (3) tick;
    chk("stall_cmd", ex_cmd, 4'b0100);
    chk("stall_valid", {3'b0, ex_valid}, 4'd1);
    chk("stall_sr", sr, 4'b0010);
    drive(1, 4'b0100, 4'he, 0, 0, 0, 1, 4'b1001); #1;
    chk("flush_ready", {3'b0, in_ready}, 4'd1);
    tick;
    chk("flush_bubble", {3'b0, ex_valid}, 4'd0);
    chk("flush_sr", sr, 4'b1001);
    drive(1, 4'b0011, 4'he, 1, 0, 0, 0, 4'h0); tick;
    chk("rsb_valid", {3'b0, ex_valid}, 4'd1);
    chk("rsb_cmd", ex_cmd, 4'b0000);
    chk("rsb_wb", {3'b0, ex_wb}, 4'd0);
    chk("rsb_s", {3'b0, ex_s}, 4'd0);
    drive(1, 4'b0100, 4'he, 1, 0, 0, 0, 4'h0); tick;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {3'b0, ex_valid}, 4'd0);
    chk("arst_exec", {3'b0, ex_exec}, 4'd0);
    chk("arst_cmd", ex_cmd, 4'd0);
    chk("arst_ci_s_wb", {1'b0, ex_carry_in, ex_s, ex_wb}, 4'd0);
    chk("arst_sr", sr, 4'b0000);
    drive(0, 4'b0000, 4'he, 0, 0, 0, 0, 4'h0);
    #2 rst_n = 1'b1;
    tick;
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom),
            $urandom_range(0, 2) == 0 ? 4'he : 4'($urandom), 1'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
            4'($urandom));
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick;
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
